legv8_decode_ctrl: RTL and testbench
====================================

LEGV8_DECODE_CTRL -- requirements
Module: legv8_decode_ctrl

Interface
REQ-001 SHALL have parameter OPC_W, default 11, meaning opcode field width (bits [OPC_W-1:OPC_W-11] decoded).
REQ-002 SHALL have parameter BR_SLOTS, default 2, meaning bubble cycles inserted after a control-transfer instruction (legal range 1..15).
REQ-003 SHALL have parameter CNT_W, default 8, meaning illegal-opcode counter width.
REQ-004 SHALL have parameter SHADOW_EN, default 1, meaning 1 enables branch-shadow bubbling and 0 disables it.
REQ-005 SHALL have clock, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have reset, input, 1 bit, meaning a synchronous, active-high reset.
REQ-007 SHALL have in_valid, input, 1 bit, meaning opcode is presented.
REQ-008 SHALL have in_ready, output, 1 bit, meaning the block accepts an opcode this cycle.
REQ-009 SHALL have opcode, input, OPC_W bits, meaning the instruction opcode field.
REQ-010 SHALL have stall, input, 1 bit, meaning hold the output register and accept nothing.
REQ-011 SHALL have flush, input, 1 bit, meaning kill the output register and the shadow state.
REQ-012 SHALL have branch_resolved, input, 1 bit, meaning early end of the branch shadow.
REQ-013 SHALL have out_valid, output, 1 bit, meaning the registered control word is valid.
REQ-014 SHALL have Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Uncondbranch, Branchlink, Branchreg, not_zero and CB_instr, outputs, 1 bit each, meaning the registered control signals.
REQ-015 SHALL have ALUOp, output, 2 bits, meaning the registered ALU operation class.
REQ-016 SHALL have illegal, output, 1 bit, meaning the registered word came from an undecodable opcode.
REQ-017 SHALL have illegal_count, output, CNT_W bits, meaning a saturating count of accepted illegal opcodes.

Function
REQ-018 SHALL accept an opcode when in_valid and in_ready are both 1, and present its decoded word on the outputs the next cycle with out_valid=1 (latency 1).
REQ-019 SHALL drive in_ready = !stall && !flush && state==RUN, combinationally.
REQ-020 SHALL decode ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 and EOR 11001010000 as: RegWrite=1, ALUOp=10, all other signals 0.
REQ-021 SHALL decode LSL 11010011011 and LSR 11010011010 as: RegWrite=1, ALUSrc=1, ALUOp=10, all other signals 0.
REQ-022 SHALL decode LDUR 11111000010 as: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=00.
REQ-023 SHALL decode STUR 11111000000 as: Reg2Loc=1, ALUSrc=1, MemWrite=1, ALUOp=00.
REQ-024 SHALL decode BR 11010110000 as: RegWrite=1, Branchreg=1, ALUOp=10.
REQ-025 SHALL decode CBZ (top 8 bits 10110100) as: CB_instr=1, Reg2Loc=1, Branch=1, ALUOp=01; CBNZ (10110101) SHALL decode identically plus not_zero=1.
REQ-026 SHALL decode BL (top 6 bits 100101) as: Reg2Loc=1, RegWrite=1, Uncondbranch=1, Branchlink=1, ALUOp=01.
REQ-027 SHALL decode B (top 6 bits 000101) as: Uncondbranch=1, ALUOp=01.
REQ-028 SHALL give CB/B/BL pattern matches precedence over the exact 11-bit matches; every signal not listed for an opcode SHALL be 0.
REQ-029 SHALL treat any other opcode as illegal: all control signals 0, ALUOp=11, illegal=1, out_valid=1, and illegal_count incremented by 1 and saturated at all-ones.
REQ-030 SHALL implement an FSM with states RUN and SHADOW; RUN->SHADOW when an accepted opcode decodes with Branch, Uncondbranch or Branchreg set and SHADOW_EN=1, loading the shadow counter with BR_SLOTS.
REQ-031 SHALL, in SHADOW, output bubbles (out_valid=0, all control signals 0, ALUOp=00) and decrement the counter on each non-stalled cycle; it SHALL go SHADOW->RUN when the counter decrements to 0 or when branch_resolved=1.
REQ-032 SHALL, on stall=1 with flush=0, hold every output and the FSM state/counter unchanged; branch_resolved is ignored.
REQ-033 SHALL give flush priority over stall: the next cycle out_valid=0, all control signals 0, ALUOp=00, illegal=0, FSM=RUN, counter=0; illegal_count is unchanged.
REQ-034 SHALL, with in_valid=0 in RUN and no stall, register a bubble (out_valid=0, all control signals 0).

Reset
REQ-035 SHALL, on reset=1 at a clock edge, override flush and stall and set: out_valid=0, all control outputs 0, ALUOp=00, illegal=0, illegal_count=0, FSM=RUN, counter=0.
REQ-036 SHALL drive in_ready=0 while reset=1; reset mid-SHADOW SHALL abandon the shadow immediately.

Verification
REQ-037 SHALL pass: ADD, LDUR, STUR back-to-back with in_valid=1 -> cycles 1..3: RegWrite=1/ALUOp=10; then MemRead=1/MemtoReg=1; then MemWrite=1/Reg2Loc=1; out_valid=1 throughout.
REQ-038 SHALL pass: CBNZ accepted (BR_SLOTS=2) -> CBNZ word with not_zero=1, then 2 bubble cycles with in_ready=0, then in_ready=1.
REQ-039 SHALL pass: B accepted, then branch_resolved=1 on the first shadow cycle -> exactly one bubble, after which in_ready=1.
REQ-040 SHALL pass: opcode 00000000000 three times (CNT_W=2), then a fourth -> illegal=1 each time, ALUOp=11, illegal_count=1,2,3,3.
REQ-041 SHALL pass: stall=1 for 3 cycles after LSL -> LSL word held; then stall=1 with flush=1 -> out_valid=0, FSM=RUN.
REQ-042 SHALL pass: reset asserted during SHADOW -> next cycle all outputs 0, illegal_count=0, in_ready=1 once reset=0.

Source files
------------

// File: rtl/legv8_decode_ctrl.sv
// LEGv8 main-control decoder with a registered control word, a branch-shadow
// bubbling FSM and a saturating illegal-opcode counter.
module legv8_decode_ctrl #(
    parameter int OPC_W     = 11,
    parameter int BR_SLOTS  = 2,
    parameter int CNT_W     = 8,
    parameter int SHADOW_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] opcode,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_resolved,
    output logic             out_valid,
    output logic             Reg2Loc,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             Uncondbranch,
    output logic             Branchlink,
    output logic             Branchreg,
    output logic             not_zero,
    output logic             CB_instr,
    output logic [1:0]       ALUOp,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    // state  | meaning
    // RUN    | accepting opcodes, one decoded word per accepted opcode
    // SHADOW | emitting bubbles for the branch delay, counter counts down
    typedef enum logic {RUN, SHADOW} state_t;

    typedef struct packed {
        logic       reg2loc;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       uncondbranch;
        logic       branchlink;
        logic       branchreg;
        logic       not_zero;
        logic       cb_instr;
        logic [1:0] aluop;
        logic       illegal;
    } ctrl_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    ctrl_t            word_q, word_d, dec;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic [10:0]      op11;

    assign op11 = opcode[OPC_W-1 -: 11];

    // Pattern-matched branch classes sit first so they win over exact matches.
    always_comb begin
        dec = '0;
        casez (op11)
            11'b10110100???: begin
                dec.cb_instr = 1'b1; dec.reg2loc = 1'b1; dec.branch = 1'b1; dec.aluop = 2'b01;
            end
            11'b10110101???: begin
                dec.cb_instr = 1'b1; dec.reg2loc = 1'b1; dec.branch = 1'b1; dec.aluop = 2'b01;
                dec.not_zero = 1'b1;
            end
            11'b100101?????: begin
                dec.reg2loc = 1'b1; dec.regwrite = 1'b1; dec.uncondbranch = 1'b1;
                dec.branchlink = 1'b1; dec.aluop = 2'b01;
            end
            11'b000101?????: begin
                dec.uncondbranch = 1'b1; dec.aluop = 2'b01;
            end
            11'b10001011000, 11'b11001011000, 11'b10001010000,
            11'b10101010000, 11'b11001010000: begin
                dec.regwrite = 1'b1; dec.aluop = 2'b10;
            end
            11'b11010011011, 11'b11010011010: begin
                dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 2'b10;
            end
            11'b11111000010: begin
                dec.alusrc = 1'b1; dec.memtoreg = 1'b1; dec.regwrite = 1'b1; dec.memread = 1'b1;
            end
            11'b11111000000: begin
                dec.reg2loc = 1'b1; dec.alusrc = 1'b1; dec.memwrite = 1'b1;
            end
            11'b11010110000: begin
                dec.regwrite = 1'b1; dec.branchreg = 1'b1; dec.aluop = 2'b10;
            end
            default: begin
                dec.aluop = 2'b11; dec.illegal = 1'b1;
            end
        endcase
    end

    assign in_ready = !reset && !stall && !flush && (state_q == RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = valid_q;
        icnt_d  = icnt_q;
        if (flush) begin
            state_d = RUN;
            cnt_d   = '0;
            word_d  = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            word_d  = '0;
            valid_d = 1'b0;
            case (state_q)
                RUN: begin
                    if (in_valid) begin
                        word_d  = dec;
                        valid_d = 1'b1;
                        if (dec.illegal && (icnt_q != '1))
                            icnt_d = icnt_q + CNT_W'(1);
                        if ((SHADOW_EN != 0) && (dec.branch || dec.uncondbranch || dec.branchreg)) begin
                            state_d = SHADOW;
                            cnt_d   = 4'(BR_SLOTS);
                        end
                    end
                end
                SHADOW: begin
                    if (branch_resolved || (cnt_q <= 4'd1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            icnt_q  <= icnt_d;
        end
    end

    assign out_valid     = valid_q;
    assign Reg2Loc       = word_q.reg2loc;
    assign ALUSrc        = word_q.alusrc;
    assign MemtoReg      = word_q.memtoreg;
    assign RegWrite      = word_q.regwrite;
    assign MemRead       = word_q.memread;
    assign MemWrite      = word_q.memwrite;
    assign Branch        = word_q.branch;
    assign Uncondbranch  = word_q.uncondbranch;
    assign Branchlink    = word_q.branchlink;
    assign Branchreg     = word_q.branchreg;
    assign not_zero      = word_q.not_zero;
    assign CB_instr      = word_q.cb_instr;
    assign ALUOp         = word_q.aluop;
    assign illegal       = word_q.illegal;
    assign illegal_count = icnt_q;

endmodule

// File: tb/tb_legv8_decode_ctrl.sv
// Bench for legv8_decode_ctrl: directed scenarios plus random traffic, all
// checked against a table-driven decode model and a cycle-level shadow model.
module tb_legv8_decode_ctrl;

    localparam int OPC_W    = 11;
    localparam int BR_SLOTS = 2;
    localparam int CNT_W    = 2;

    logic             clock = 1'b0;
    logic             reset, in_valid, stall, flush, branch_resolved;
    logic [OPC_W-1:0] opcode;
    logic             in_ready, out_valid;
    logic             Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
    logic             Branch, Uncondbranch, Branchlink, Branchreg, not_zero, CB_instr;
    logic [1:0]       ALUOp;
    logic             illegal;
    logic [CNT_W-1:0] illegal_count;

    legv8_decode_ctrl #(.OPC_W(OPC_W), .BR_SLOTS(BR_SLOTS), .CNT_W(CNT_W), .SHADOW_EN(1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .stall(stall), .flush(flush), .branch_resolved(branch_resolved),
        .out_valid(out_valid), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .Uncondbranch(Uncondbranch), .Branchlink(Branchlink), .Branchreg(Branchreg),
        .not_zero(not_zero), .CB_instr(CB_instr), .ALUOp(ALUOp), .illegal(illegal),
        .illegal_count(illegal_count)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word order: Reg2Loc ALUSrc MemtoReg RegWrite MemRead MemWrite Branch
    // Uncondbranch Branchlink Branchreg not_zero CB_instr ALUOp[1:0] illegal
    localparam int NT = 13;
    logic [10:0] t_pat [NT];
    logic [10:0] t_msk [NT];
    logic [14:0] t_wrd [NT];
    bit          t_br  [NT];

    function automatic logic [14:0] w(input string sigs, input logic [1:0] aop);
        logic [14:0] r = '0;
        for (int i = 0; i < sigs.len(); i++) begin
            case (sigs[i])
                "R": r[14] = 1'b1;  "A": r[13] = 1'b1;  "M": r[12] = 1'b1;
                "W": r[11] = 1'b1;  "r": r[10] = 1'b1;  "w": r[9]  = 1'b1;
                "B": r[8]  = 1'b1;  "U": r[7]  = 1'b1;  "L": r[6]  = 1'b1;
                "G": r[5]  = 1'b1;  "N": r[4]  = 1'b1;  "C": r[3]  = 1'b1;
                default: ;
            endcase
        end
        r[2:1] = aop;
        return r;
    endfunction

    task automatic tbl(input int i, input logic [10:0] p, input logic [10:0] m,
                       input logic [14:0] wd, input bit br);
        t_pat[i] = p; t_msk[i] = m; t_wrd[i] = wd; t_br[i] = br;
    endtask

    initial begin
        tbl(0,  11'b10110100000, 11'b11111111000, w("CRB",  2'b01), 1);
        tbl(1,  11'b10110101000, 11'b11111111000, w("CRBN", 2'b01), 1);
        tbl(2,  11'b10010100000, 11'b11111100000, w("RWUL", 2'b01), 1);
        tbl(3,  11'b00010100000, 11'b11111100000, w("U",    2'b01), 1);
        tbl(4,  11'b10001011000, 11'h7FF, w("W",    2'b10), 0);
        tbl(5,  11'b11001011000, 11'h7FF, w("W",    2'b10), 0);
        tbl(6,  11'b10001010000, 11'h7FF, w("W",    2'b10), 0);
        tbl(7,  11'b10101010000, 11'h7FF, w("W",    2'b10), 0);
        tbl(8,  11'b11001010000, 11'h7FF, w("W",    2'b10), 0);
        tbl(9,  11'b11010011011, 11'h7FF, w("WA",   2'b10), 0);
        tbl(10, 11'b11010011010, 11'h7FF, w("WA",   2'b10), 0);
        tbl(11, 11'b11111000010, 11'h7FF, w("AMWr", 2'b00), 0);
        tbl(12, 11'b11111000000, 11'h7FF, w("RAw",  2'b00), 0);
    end
    // BR lives outside the table loop bound so it can be added without reshaping.
    localparam logic [10:0] OP_BR = 11'b11010110000;

    function automatic void model_decode(input logic [10:0] op, output logic [14:0] wd, output bit br);
        if (op == OP_BR) begin
            wd = w("WG", 2'b10); br = 1; return;
        end
        for (int i = 0; i < NT; i++) begin
            if ((op & t_msk[i]) == t_pat[i]) begin
                wd = t_wrd[i]; br = t_br[i]; return;
            end
        end
        wd = 15'b0_0000_0000_0011_1; br = 0;
    endfunction

    logic [14:0] m_word;
    bit          m_valid;
    int          m_shadow;
    int          m_icnt;

    function automatic bit model_ready();
        return !reset && !stall && !flush && (m_shadow == 0);
    endfunction

    task automatic model_step();
        logic [14:0] wd;
        bit br;
        if (reset) begin
            m_word = '0; m_valid = 0; m_shadow = 0; m_icnt = 0;
        end else if (flush) begin
            m_word = '0; m_valid = 0; m_shadow = 0;
        end else if (stall) begin
        end else if (m_shadow > 0) begin
            m_word = '0; m_valid = 0;
            m_shadow = branch_resolved ? 0 : m_shadow - 1;
        end else if (in_valid) begin
            model_decode(opcode, wd, br);
            m_word = wd; m_valid = 1;
            if (wd[0] && m_icnt < (1 << CNT_W) - 1) m_icnt++;
            if (br) m_shadow = BR_SLOTS;
        end else begin
            m_word = '0; m_valid = 0;
        end
    endtask

    logic [14:0] dut_word;
    assign dut_word = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
                       Uncondbranch, Branchlink, Branchreg, not_zero, CB_instr, ALUOp, illegal};

    bit rdy_seen;

    task automatic cyc(input bit rst, input bit iv, input logic [10:0] op,
                       input bit st, input bit fl, input bit br);
        @(negedge clock);
        reset = rst; in_valid = iv; opcode = op; stall = st; flush = fl; branch_resolved = br;
        #1;
        rdy_seen = in_ready;
        check("in_ready", 32'(in_ready), 32'(model_ready()));
        @(posedge clock);
        model_step();
        #1;
        check("word", 32'(dut_word), 32'(m_word));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("illegal_count", 32'(illegal_count), 32'(m_icnt));
    endtask

    function automatic logic [10:0] rand_op();
        int k;
        if ($urandom_range(0, 9) < 7) begin
            k = $urandom_range(0, NT);
            if (k == NT) return OP_BR;
            return t_pat[k] | (11'($urandom) & ~t_msk[k]);
        end
        return 11'($urandom);
    endfunction

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_CBNZ = 11'b10110101101;
    localparam logic [10:0] OP_B    = 11'b00010100011;

    initial begin
        reset = 1; in_valid = 0; opcode = '0; stall = 0; flush = 0; branch_resolved = 0;
        m_word = '0; m_valid = 0; m_shadow = 0; m_icnt = 0;
        cyc(1, 1, OP_ADD, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("reset_ready_low", 32'(rdy_seen), 0);

        // ADD, LDUR, STUR back-to-back
        cyc(0, 1, OP_ADD, 0, 0, 0);
        check("add_regwrite", 32'({RegWrite, ALUOp, out_valid}), 32'b1101);
        cyc(0, 1, OP_LDUR, 0, 0, 0);
        check("ldur_mem", 32'({MemRead, MemtoReg, out_valid}), 32'b111);
        cyc(0, 1, OP_STUR, 0, 0, 0);
        check("stur_mem", 32'({MemWrite, Reg2Loc, out_valid}), 32'b111);

        // CBNZ then two shadow cycles
        cyc(0, 1, OP_CBNZ, 0, 0, 0);
        check("cbnz_nz", 32'({not_zero, CB_instr, Branch}), 32'b111);
        cyc(0, 1, OP_ADD, 0, 0, 0);
        check("cbnz_shadow1_ready", 32'(rdy_seen), 0);
        cyc(0, 1, OP_ADD, 0, 0, 0);
        check("cbnz_shadow2_ready", 32'(rdy_seen), 0);
        check("cbnz_bubble", 32'(out_valid), 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("cbnz_ready_after", 32'(rdy_seen), 1);

        // B with early resolution: one bubble
        cyc(0, 1, OP_B, 0, 0, 0);
        cyc(0, 1, OP_ADD, 0, 0, 1);
        check("b_one_bubble", 32'(out_valid), 0);
        cyc(0, 1, OP_ADD, 0, 0, 0);
        check("b_ready_after", 32'(rdy_seen), 1);

        // illegal counter saturation
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 1, 11'b0, 0, 0, 0);
            check("illegal_flag", 32'({illegal, ALUOp}), 32'b111);
            check("illegal_sat", 32'(illegal_count), (i > 3) ? 3 : i);
        end

        // stall holds LSL, then stall+flush clears
        cyc(0, 1, OP_LSL, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, OP_STUR, 1, 0, 0);
            check("lsl_held", 32'({ALUSrc, RegWrite, out_valid}), 32'b111);
        end
        cyc(0, 1, OP_STUR, 1, 1, 0);
        check("flush_clears", 32'(out_valid), 0);
        cyc(0, 1, OP_ADD, 0, 0, 0);
        check("flush_run", 32'(out_valid), 1);

        // reset mid-shadow
        cyc(0, 1, OP_CBNZ, 0, 0, 0);
        cyc(1, 1, OP_ADD, 0, 0, 0);
        check("rst_clear", 32'({dut_word, out_valid, illegal_count}), 0);
        cyc(0, 1, OP_ADD, 0, 0, 0);
        check("rst_ready", 32'(rdy_seen), 1);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 8, rand_op(),
                $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 4) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
